// File: rtl/branch_sched_pkg.sv
// Shared encodings for the ID-stage branch scheduler: branch classes,
// comparator results and scheduler FSM states.
// Raw branch codes above JR decode to NONE via decode_type().
package branch_sched_pkg;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLEZ = 4'd3,
        BR_BGTZ = 4'd4,
        BR_BLTZ = 4'd5,
        BR_BGEZ = 4'd6,
        BR_J    = 4'd7,
        BR_JAL  = 4'd8,
        BR_JR   = 4'd9
    } br_type_e;

    typedef enum logic [1:0] {
        CMP_EQ   = 2'b00,
        CMP_BIG  = 2'b01,
        CMP_LESS = 2'b10
    } cmp_res_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Unused encodings 10..15 behave exactly like NONE.
    function automatic br_type_e decode_type(input logic [3:0] raw);
        if (raw > 4'd9) begin
            return BR_NONE;
        end
        return br_type_e'(raw);
    endfunction

endpackage

// File: rtl/branch_sched_if.sv
// ID-stage <-> branch scheduler bundle: decoded branch, forwarded operands,
// stall back to IF/ID and the registered redirect/link pulses toward IF.
// master = decoder/hazard side, slave = branch_sched.
interface branch_sched_if;
    logic        id_valid;
    logic [3:0]  id_br_type;
    logic [31:0] id_pc;
    logic [15:0] id_imm16;
    logic [25:0] id_index;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rs_ready;
    logic        rt_ready;
    logic        id_flush;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        link_valid;
    logic [31:0] link_pc;

    modport master (
        output id_valid, id_br_type, id_pc, id_imm16, id_index,
               rs_data, rt_data, rs_ready, rt_ready, id_flush,
        input  stall, redirect_valid, redirect_pc, link_valid, link_pc
    );

    modport slave (
        input  id_valid, id_br_type, id_pc, id_imm16, id_index,
               rs_data, rt_data, rs_ready, rt_ready, id_flush,
        output stall, redirect_valid, redirect_pc, link_valid, link_pc
    );
endinterface

// File: rtl/branch_sched_cmp.sv
// Signed 32-bit comparator: reports a==b, a>b or a<b.
// Purely combinational, zero latency.
// No flow control.
module branch_sched_cmp
    import branch_sched_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output cmp_res_e    res
);

    // Equality first, then signed magnitude.
    always_comb begin
        res = CMP_LESS;
        if (a == b) begin
            res = CMP_EQ;
        end else if ($signed(a) > $signed(b)) begin
            res = CMP_BIG;
        end
    end

endmodule

// File: rtl/branch_sched.sv
// Holds an ID-stage branch/jump until its operands are final, resolves it and issues a PC redirect.
// Redirect/link pulse one cycle after the resolve cycle; stall is combinational in the same cycle.
// Asserts stall while a needed operand is not ready; id_flush drops the held branch.
module branch_sched
    import branch_sched_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    branch_sched_if.slave    bus,
    output logic [CNT_W-1:0] br_total,
    output logic [CNT_W-1:0] br_taken
);

    state_e      state;
    br_type_e    br_type;
    cmp_res_e    cmp_res;
    logic        is_br, need_rs, need_rt, needs_met;
    logic        held, resolve, taken, zero_cmp;
    logic [31:0] cmp_b, pc_plus4, br_target, target;
    logic        redirect_valid_q, link_valid_q;
    logic [31:0] redirect_pc_q, link_pc_q;

    assign br_type   = decode_type(bus.id_br_type);
    assign is_br     = (br_type != BR_NONE);
    assign pc_plus4  = bus.id_pc + 32'd4;
    assign br_target = pc_plus4 + {{14{bus.id_imm16[15]}}, bus.id_imm16, 2'b00};

    // Operand needs per branch class; single-operand classes compare against zero.
    always_comb begin
        need_rs  = 1'b0;
        need_rt  = 1'b0;
        zero_cmp = 1'b1;
        case (br_type)
            BR_BEQ, BR_BNE: begin
                need_rs  = 1'b1;
                need_rt  = 1'b1;
                zero_cmp = 1'b0;
            end
            BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ, BR_JR: need_rs = 1'b1;
            default: ;
        endcase
    end

    assign needs_met = (!need_rs || bus.rs_ready) && (!need_rt || bus.rt_ready);
    // A branch occupies the scheduler when already waiting or newly presented in IDLE.
    assign held      = (state == ST_WAIT) || (bus.id_valid && is_br);
    assign resolve   = held && needs_met && !bus.id_flush;
    assign bus.stall = held && !needs_met && !bus.id_flush;
    assign cmp_b     = zero_cmp ? 32'd0 : bus.rt_data;

    branch_sched_cmp u_cmp (
        .a   (bus.rs_data),
        .b   (cmp_b),
        .res (cmp_res)
    );

    // Taken decision and target selection from the comparator result.
    always_comb begin
        taken  = 1'b0;
        target = br_target;
        case (br_type)
            BR_BEQ:  taken = (cmp_res == CMP_EQ);
            BR_BNE:  taken = (cmp_res != CMP_EQ);
            BR_BLEZ: taken = (cmp_res == CMP_EQ) || (cmp_res == CMP_LESS);
            BR_BGTZ: taken = (cmp_res == CMP_BIG);
            BR_BLTZ: taken = (cmp_res == CMP_LESS);
            BR_BGEZ: taken = (cmp_res == CMP_EQ) || (cmp_res == CMP_BIG);
            BR_J, BR_JAL: begin
                taken  = 1'b1;
                target = {pc_plus4[31:28], bus.id_index, 2'b00};
            end
            BR_JR: begin
                taken  = 1'b1;
                target = bus.rs_data;
            end
            default: ;
        endcase
    end

    // FSM, registered redirect/link pulses and saturating statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            link_valid_q     <= 1'b0;
            link_pc_q        <= 32'd0;
            br_total         <= '0;
            br_taken         <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.id_valid && is_br && !bus.id_flush && !needs_met) state <= ST_WAIT;
                ST_WAIT: if (bus.id_flush || needs_met) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            redirect_valid_q <= resolve && taken;
            link_valid_q     <= resolve && taken && (br_type == BR_JAL);
            if (resolve && taken) begin
                redirect_pc_q <= target;
            end
            if (resolve && taken && (br_type == BR_JAL)) begin
                link_pc_q <= bus.id_pc + 32'd8;
            end
            if (resolve && (br_total != '1)) begin
                br_total <= br_total + 1'b1;
            end
            if (resolve && taken && (br_taken != '1)) begin
                br_taken <= br_taken + 1'b1;
            end
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.link_valid     = link_valid_q;
    assign bus.link_pc        = link_pc_q;

endmodule

// File: tb/tb_branch_sched.sv
// Self-checking bench for branch_sched: table of single-cycle resolves, then
// stall/flush/saturation/reset sequences; registered results go through a scoreboard queue.
module tb_branch_sched;

    localparam int CNT_W = 5;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [CNT_W-1:0] br_total, br_taken;

    branch_sched_if bus ();

    branch_sched #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .br_total (br_total),
        .br_taken (br_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ty;
        logic [31:0] pc;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rs, rt;
        logic        rs_rdy, rt_rdy;
        logic        res, tk;
        logic [31:0] rpc;
        logic        lv;
        logic [31:0] lpc;
    } vec_t;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        lv;
        logic [31:0] lpc;
        int          tot, tak;
    } exp_t;

    vec_t tbl[19];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_tot = 0;
    int   m_tak = 0;

    function automatic vec_t mk(logic [3:0] ty, logic [31:0] pc, logic [15:0] imm, logic [25:0] idx,
                                logic [31:0] rs, logic [31:0] rt, logic rsr, logic rtr,
                                logic res, logic tk, logic [31:0] rpc, logic lv, logic [31:0] lpc);
        vec_t v;
        v.ty = ty; v.pc = pc; v.imm = imm; v.idx = idx; v.rs = rs; v.rt = rt;
        v.rs_rdy = rsr; v.rt_rdy = rtr; v.res = res; v.tk = tk; v.rpc = rpc; v.lv = lv; v.lpc = lpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic vld, input logic [3:0] ty, input logic [31:0] pc,
                         input logic [15:0] imm, input logic [25:0] idx,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic rsr, input logic rtr, input logic flush);
        bus.id_valid = vld; bus.id_br_type = ty; bus.id_pc = pc; bus.id_imm16 = imm;
        bus.id_index = idx; bus.rs_data = rs; bus.rt_data = rt;
        bus.rs_ready = rsr; bus.rt_ready = rtr; bus.id_flush = flush;
    endtask

    // One cycle: inputs applied just after an edge, stall checked mid-cycle,
    // expected registered outputs queued and compared just after the next edge.
    task automatic step(input logic vld, input logic [3:0] ty, input logic [31:0] pc,
                        input logic [15:0] imm, input logic [25:0] idx,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic rsr, input logic rtr, input logic flush,
                        input logic exp_stall, input logic res, input logic tk,
                        input logic [31:0] rpc, input logic lv, input logic [31:0] lpc);
        exp_t e;
        drive(vld, ty, pc, imm, idx, rs, rt, rsr, rtr, flush);
        #3;
        chk("stall", {31'd0, bus.stall}, {31'd0, exp_stall});
        if (res) begin
            if (m_tot < SAT) m_tot++;
            if (tk && m_tak < SAT) m_tak++;
        end
        e.rv = res && tk; e.rpc = rpc; e.lv = res && tk && lv; e.lpc = lpc;
        e.tot = m_tot; e.tak = m_tak;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, e.rv});
        if (e.rv) chk("redirect_pc", bus.redirect_pc, e.rpc);
        chk("link_valid", {31'd0, bus.link_valid}, {31'd0, e.lv});
        if (e.lv) chk("link_pc", bus.link_pc, e.lpc);
        chk("br_total", 32'(br_total), 32'(e.tot));
        chk("br_taken", 32'(br_taken), 32'(e.tak));
    endtask

    task automatic check_reset_outputs();
        chk("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("rst_link_valid", {31'd0, bus.link_valid}, 32'd0);
        chk("rst_link_pc", bus.link_pc, 32'd0);
        chk("rst_br_total", 32'(br_total), 32'd0);
        chk("rst_br_taken", 32'(br_taken), 32'd0);
    endtask

    initial begin
        //          ty    pc            imm       idx          rs            rt            rsr  rtr  res  tk   rpc           lv   lpc
        tbl[0]  = mk(4'd1, 32'h0000_3000, 16'h0004, 26'h0,       32'h5,        32'h5,        1'b1,1'b1,1'b1,1'b1,32'h0000_3014,1'b0,32'h0);
        tbl[1]  = mk(4'd4, 32'h0000_3100, 16'h0008, 26'h0,       32'hFFFF_FFFF,32'h0,        1'b1,1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0);
        tbl[2]  = mk(4'd5, 32'h0000_0100, 16'h0010, 26'h0,       32'hFFFF_FFFF,32'h0,        1'b1,1'b0,1'b1,1'b1,32'h0000_0144,1'b0,32'h0);
        tbl[3]  = mk(4'd2, 32'h0000_2000, 16'hFFFE, 26'h0,       32'h1,        32'h2,        1'b1,1'b1,1'b1,1'b1,32'h0000_1FFC,1'b0,32'h0);
        tbl[4]  = mk(4'd2, 32'h0000_2000, 16'h0004, 26'h0,       32'h7,        32'h7,        1'b1,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0);
        tbl[5]  = mk(4'd3, 32'h0000_0400, 16'h0001, 26'h0,       32'h0,        32'h0,        1'b1,1'b0,1'b1,1'b1,32'h0000_0408,1'b0,32'h0);
        tbl[6]  = mk(4'd3, 32'h0000_0400, 16'h0001, 26'h0,       32'h1,        32'h0,        1'b1,1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0);
        tbl[7]  = mk(4'd3, 32'h0000_0600, 16'h0000, 26'h0,       32'hFFFF_FFF0,32'h0,        1'b1,1'b0,1'b1,1'b1,32'h0000_0604,1'b0,32'h0);
        tbl[8]  = mk(4'd6, 32'h0000_0010, 16'h0002, 26'h0,       32'h0,        32'h0,        1'b1,1'b0,1'b1,1'b1,32'h0000_001C,1'b0,32'h0);
        tbl[9]  = mk(4'd6, 32'h0000_0010, 16'h0002, 26'h0,       32'h8000_0000,32'h0,        1'b1,1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0);
        tbl[10] = mk(4'd4, 32'h0000_0000, 16'h0000, 26'h0,       32'h7FFF_FFFF,32'h0,        1'b1,1'b0,1'b1,1'b1,32'h0000_0004,1'b0,32'h0);
        tbl[11] = mk(4'd7, 32'h8000_3000, 16'h0000, 26'h3FFFFFF, 32'h0,        32'h0,        1'b0,1'b0,1'b1,1'b1,32'h8FFF_FFFC,1'b0,32'h0);
        tbl[12] = mk(4'd8, 32'h8000_3000, 16'h0000, 26'h0000100, 32'h0,        32'h0,        1'b0,1'b0,1'b1,1'b1,32'h8000_0400,1'b1,32'h8000_3008);
        tbl[13] = mk(4'd9, 32'h0000_0200, 16'h0000, 26'h0,       32'h0000_3ABC,32'h0,        1'b1,1'b0,1'b1,1'b1,32'h0000_3ABC,1'b0,32'h0);
        tbl[14] = mk(4'd1, 32'h0000_0200, 16'h0004, 26'h0,       32'hFFFF_FFFF,32'h1,        1'b1,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0);
        tbl[15] = mk(4'd12,32'h0000_0200, 16'h0004, 26'h0,       32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0);
        tbl[16] = mk(4'd1, 32'h0000_0000, 16'hFFFF, 26'h0,       32'h9,        32'h9,        1'b1,1'b1,1'b1,1'b1,32'h0000_0000,1'b0,32'h0);
        tbl[17] = mk(4'd4, 32'h0000_0000, 16'h0004, 26'h0,       32'h0,        32'h0,        1'b1,1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0);
        tbl[18] = mk(4'd2, 32'h0000_0040, 16'h7FFF, 26'h0,       32'h8000_0000,32'h7FFF_FFFF,1'b1,1'b1,1'b1,1'b1,32'h0002_0040,1'b0,32'h0);

        drive(1'b0, 4'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #12;
        check_reset_outputs();
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back single-cycle resolves.
        for (int i = 0; i < 19; i++) begin
            step(1'b1, tbl[i].ty, tbl[i].pc, tbl[i].imm, tbl[i].idx, tbl[i].rs, tbl[i].rt,
                 tbl[i].rs_rdy, tbl[i].rt_rdy, 1'b0, 1'b0, tbl[i].res, tbl[i].tk,
                 tbl[i].rpc, tbl[i].lv, tbl[i].lpc);
        end

        // BNE waits three cycles on rt; rs wobbles during WAIT, only the resolve-cycle value counts.
        step(1'b1, 4'd2, 32'h500, 16'h3, 26'h0, 32'h2, 32'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 4'd2, 32'h500, 16'h3, 26'h0, 32'h2, 32'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 4'd2, 32'h500, 16'h3, 26'h0, 32'h2, 32'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 4'd2, 32'h500, 16'h3, 26'h0, 32'h1, 32'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h510, 1'b0, 32'h0);

        // Flush in WAIT wins over operand arrival; afterwards the block is idle again.
        step(1'b1, 4'd2, 32'h700, 16'h3, 26'h0, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 4'd2, 32'h700, 16'h3, 26'h0, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 4'd2, 32'h700, 16'h3, 26'h0, 32'h1, 32'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Drive both counters into saturation, then one more taken and one not-taken.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 4'd1, 32'h3000, 16'h4, 26'h0, 32'h5, 32'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3014, 1'b0, 32'h0);
        end
        chk("sat_total", 32'(br_total), 32'(SAT));
        chk("sat_taken", 32'(br_taken), 32'(SAT));
        step(1'b1, 4'd2, 32'h3000, 16'h4, 26'h0, 32'h5, 32'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset while a branch waits: outputs clear asynchronously, then IDLE with no stall.
        step(1'b1, 4'd7, 32'h1000, 16'h0, 26'h20, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        drive(1'b1, 4'd2, 32'h900, 16'h1, 26'h0, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
        #2;
        chk("wait_stall", {31'd0, bus.stall}, 32'd1);
        chk("pre_rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        drive(1'b0, 4'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_mid_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_tot = 0;
        m_tak = 0;
        step(1'b0, 4'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 4'd1, 32'h3000, 16'h4, 26'h0, 32'h5, 32'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3014, 1'b0, 32'h0);
        step(1'b0, 4'd0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
